// File: rtl/ahb_slave_arbiter_if.sv
// rtl/ahb_slave_arbiter_if.sv - request/control inputs and grant/ready outputs of one slave-port arbiter
interface ahb_slave_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0]   req;
    logic [2*NUM_MASTERS-1:0] htrans;
    logic [3*NUM_MASTERS-1:0] hburst;
    logic [NUM_MASTERS-1:0]   mastlock;
    logic                     HREADY;
    logic [NUM_MASTERS-1:0]   addr_gnt;
    logic [NUM_MASTERS-1:0]   data_gnt;
    logic [NUM_MASTERS-1:0]   hready_m;

    // matrix side: drives requests and slave HREADYOUT, receives grants
    modport master (
        output req, htrans, hburst, mastlock, HREADY,
        input  addr_gnt, data_gnt, hready_m
    );

    // arbiter side
    modport slave (
        input  req, htrans, hburst, mastlock, HREADY,
        output addr_gnt, data_gnt, hready_m
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - AHB-Lite per-slave-port arbiter; AHB_ARB_RR_EN selects round-robin, otherwise fixed priority
module ahb_slave_arbiter #(
    parameter int NUM_MASTERS = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_slave_arbiter_if.slave bus
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [2:0] HB_WRAP4  = 3'd2;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_WRAP8  = 3'd4;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_WRAP16 = 3'd6;
    localparam logic [2:0] HB_INCR16 = 3'd7;

    logic [NUM_MASTERS-1:0] r_addr_gnt;
    logic [NUM_MASTERS-1:0] r_data_gnt;
    logic [3:0]             r_burst_cnt;

    logic [1:0]             w_own_trans;
    logic [2:0]             w_own_burst;
    logic                   w_own_lock;
    logic [3:0]             w_cnt_nxt;
    logic                   w_hold;
    logic [NUM_MASTERS-1:0] w_arb;
    logic                   w_arb_found;
    logic [NUM_MASTERS-1:0] w_gnt_nxt;
    logic [NUM_MASTERS-1:0] w_data_nxt;
    logic [NUM_MASTERS-1:0] w_hready_m;

    // control of the current address-phase owner; all zero (IDLE) when nobody owns the port
    always_comb begin
        w_own_trans = TR_IDLE;
        w_own_burst = HB_SINGLE;
        w_own_lock  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_addr_gnt[i]) begin
                w_own_trans = bus.htrans[2*i +: 2];
                w_own_burst = bus.hburst[3*i +: 3];
                w_own_lock  = bus.mastlock[i];
            end
        end
    end

    // remaining-beat counter: NONSEQ loads beats-1, SEQ counts down, IDLE cuts the burst short, BUSY pauses
    always_comb begin
        w_cnt_nxt = r_burst_cnt;
        case (w_own_trans)
            TR_IDLE:   w_cnt_nxt = 4'd0;
            TR_BUSY:   w_cnt_nxt = r_burst_cnt;
            TR_NONSEQ: begin
                case (w_own_burst)
                    HB_INCR4, HB_WRAP4:   w_cnt_nxt = 4'd3;
                    HB_INCR8, HB_WRAP8:   w_cnt_nxt = 4'd7;
                    HB_INCR16, HB_WRAP16: w_cnt_nxt = 4'd15;
                    default:              w_cnt_nxt = 4'd0;
                endcase
            end
            TR_SEQ:    w_cnt_nxt = (r_burst_cnt != 4'd0) ? (r_burst_cnt - 4'd1) : 4'd0;
            default:   w_cnt_nxt = 4'd0;
        endcase
    end

    // owner keeps the port while locked, while fixed-length beats remain, or while an INCR burst continues
    always_comb begin
        w_hold = (r_addr_gnt != '0) &&
                 (w_own_lock || (w_cnt_nxt != 4'd0) ||
                  ((w_own_burst == HB_INCR) && ((w_own_trans == TR_SEQ) || (w_own_trans == TR_BUSY))));
    end

`ifdef AHB_ARB_RR_EN
    logic [IW-1:0] r_last_gnt;
    logic [IW-1:0] w_gnt_idx;
    logic [IW-1:0] w_cand;

    // round-robin search starting just after the last master granted
    always_comb begin
        w_arb       = '0;
        w_arb_found = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int v_pos;
            v_pos = int'(r_last_gnt) + k;
            if (v_pos >= NUM_MASTERS) begin
                v_pos = v_pos - NUM_MASTERS;
            end
            w_cand = IW'(v_pos);
            if (!w_arb_found && bus.req[w_cand]) begin
                w_arb_found    = 1'b1;
                w_arb[w_cand]  = 1'b1;
            end
        end
    end

    // index of the next grant, used to move the round-robin pointer
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_gnt_nxt[i]) begin
                w_gnt_idx = IW'(i);
            end
        end
    end

    // pointer follows each new nonzero grant; reset value makes master 0 win first
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_last_gnt <= IW'(NUM_MASTERS - 1);
        end else if (bus.HREADY && (w_gnt_nxt != '0) && (w_gnt_nxt != r_addr_gnt)) begin
            r_last_gnt <= w_gnt_idx;
        end
    end
`else
    // fixed priority: lowest requesting index wins
    always_comb begin
        w_arb       = '0;
        w_arb_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_arb_found && bus.req[i]) begin
                w_arb_found = 1'b1;
                w_arb[i]    = 1'b1;
            end
        end
    end
`endif

    // next grants: address phase held or re-arbitrated, data phase inherits an active address phase
    always_comb begin
        w_gnt_nxt  = w_hold ? r_addr_gnt : w_arb;
        w_data_nxt = ((w_own_trans == TR_NONSEQ) || (w_own_trans == TR_SEQ)) ? r_addr_gnt : '0;
    end

    // ownership registers advance only when the slave accepts (HREADY high)
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr_gnt  <= '0;
            r_data_gnt  <= '0;
            r_burst_cnt <= 4'd0;
        end else if (bus.HREADY) begin
            r_addr_gnt  <= w_gnt_nxt;
            r_data_gnt  <= w_data_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    // owners see the slave's HREADY, waiting requesters are stalled, idle masters see ready
    always_comb begin
        w_hready_m = '1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_addr_gnt[i] || r_data_gnt[i]) begin
                w_hready_m[i] = bus.HREADY;
            end else if (bus.req[i]) begin
                w_hready_m[i] = 1'b0;
            end
        end
    end

    assign bus.addr_gnt = r_addr_gnt;
    assign bus.data_gnt = r_data_gnt;
    assign bus.hready_m = w_hready_m;
endmodule
